// File: rtl/shift_unit_arbiter.sv
// rtl/shift_unit_arbiter.sv - round-robin arbiter sharing one 32-bit shifter between two requesters
module shift_unit_arbiter #(
    parameter int unsigned PRIO_RESET = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [31:0] i_req0_data,
    input  logic [4:0]  i_req0_shamt,
    input  logic [1:0]  i_req0_op,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [31:0] i_req1_data,
    input  logic [4:0]  i_req1_shamt,
    input  logic [1:0]  i_req1_op,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_src
);

    localparam logic PTR_RST = (PRIO_RESET != 0);

    logic        ptr_q, ptr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_src_q, rsp_src_d;

    logic        can_accept;
    logic        winner;
    logic        any_valid;
    logic        accept;
    logic [31:0] sel_data;
    logic [4:0]  sel_shamt;
    logic [1:0]  sel_op;
    logic [31:0] shift_res;

    assign can_accept = !rsp_valid_q || i_rsp_ready;
    assign any_valid  = i_req0_valid || i_req1_valid;

    // Pointer only breaks ties; a lone valid requester always wins.
    always_comb begin
        winner = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            winner = ptr_q;
        end else if (i_req1_valid) begin
            winner = 1'b1;
        end
    end

    assign o_req0_ready = i_rst_n && can_accept && any_valid && !winner && i_req0_valid;
    assign o_req1_ready = i_rst_n && can_accept && any_valid &&  winner && i_req1_valid;
    assign accept       = o_req0_ready || o_req1_ready;

    always_comb begin
        sel_data  = winner ? i_req1_data  : i_req0_data;
        sel_shamt = winner ? i_req1_shamt : i_req0_shamt;
        sel_op    = winner ? i_req1_op    : i_req0_op;
    end

    always_comb begin
        shift_res = sel_data;
        case (sel_op)
            2'b00:   shift_res = sel_data << sel_shamt;
            2'b01:   shift_res = sel_data >> sel_shamt;
            2'b11:   shift_res = 32'($signed(sel_data) >>> sel_shamt);
            default: shift_res = sel_data;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_src_d   = rsp_src_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = shift_res;
            rsp_src_d   = winner;
            ptr_d       = !winner;
        end else if (rsp_valid_q && i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q       <= PTR_RST;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_src_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_src_q   <= rsp_src_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_src   = rsp_src_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb/tb_shift_unit_arbiter.sv - directed-vector bench for shift_unit_arbiter
module tb_shift_unit_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req0_valid, i_req1_valid;
    logic        o_req0_ready, o_req1_ready;
    logic [31:0] i_req0_data, i_req1_data;
    logic [4:0]  i_req0_shamt, i_req1_shamt;
    logic [1:0]  i_req0_op, i_req1_op;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic        o_rsp_src;

    int tests_run = 0;
    int tests_failed = 0;

    shift_unit_arbiter #(.PRIO_RESET(0)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req0_valid (i_req0_valid),
        .o_req0_ready (o_req0_ready),
        .i_req0_data  (i_req0_data),
        .i_req0_shamt (i_req0_shamt),
        .i_req0_op    (i_req0_op),
        .i_req1_valid (i_req1_valid),
        .o_req1_ready (o_req1_ready),
        .i_req1_data  (i_req1_data),
        .i_req1_shamt (i_req1_shamt),
        .i_req1_op    (i_req1_op),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_src    (o_rsp_src)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        logic [31:0] fill;
        fill = d[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b11:   return (d >> s) | fill;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] rdy();
        return {30'b0, o_req1_ready, o_req0_ready};
    endfunction

    logic [31:0] v_data  [4] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h1234_5678};
    logic [4:0]  v_shamt [4] = '{5'd4, 5'd31, 5'd31, 5'd5};
    logic [1:0]  v_op    [4] = '{2'b01, 2'b00, 2'b11, 2'b10};
    logic [31:0] v_exp   [4] = '{32'h0800_0000, 32'h8000_0000, 32'h0000_0000, 32'h1234_5678};
    logic [1:0]  sweep_ops [3] = '{2'b00, 2'b01, 2'b11};

    initial begin
        i_rst_n = 1'b0;
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        i_req0_data = 32'h0; i_req1_data = 32'h0;
        i_req0_shamt = 5'd0; i_req1_shamt = 5'd0;
        i_req0_op = 2'b00; i_req1_op = 2'b00;
        i_rsp_ready = 1'b1;
        #1;
        check("rst_valid", {31'b0, o_rsp_valid}, 32'h0);
        check("rst_data", o_rsp_data, 32'h0);
        check("rst_src", {31'b0, o_rsp_src}, 32'h0);
        check("rst_ready", rdy(), 32'h0);
        tick(); tick();
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        i_rst_n = 1'b1;
        tick();

        // Requester 0 alone, SRA
        i_req0_valid = 1'b1; i_req0_op = 2'b11; i_req0_data = 32'h8000_0000; i_req0_shamt = 5'd4;
        #1 check("t1_ready", rdy(), 32'h1);
        tick();
        i_req0_valid = 1'b0;
        check("t1_valid", {31'b0, o_rsp_valid}, 32'h1);
        check("t1_data", o_rsp_data, 32'hF800_0000);
        check("t1_src", {31'b0, o_rsp_src}, 32'h0);

        // Requester 1 alone, back-to-back
        for (int i = 0; i < 4; i++) begin
            i_req1_valid = 1'b1; i_req1_data = v_data[i]; i_req1_shamt = v_shamt[i]; i_req1_op = v_op[i];
            #1 check($sformatf("t2_ready%0d", i), rdy(), 32'h2);
            tick();
            check($sformatf("t2_valid%0d", i), {31'b0, o_rsp_valid}, 32'h1);
            check($sformatf("t2_data%0d", i), o_rsp_data, v_exp[i]);
            check($sformatf("t2_src%0d", i), {31'b0, o_rsp_src}, 32'h1);
        end
        i_req1_valid = 1'b0;
        tick();
        check("t2_drain_valid", {31'b0, o_rsp_valid}, 32'h0);
        check("t2_drain_hold", o_rsp_data, 32'h1234_5678);

        // Both valid: round-robin from pointer 0
        i_req0_valid = 1'b1; i_req0_data = 32'h11; i_req0_shamt = 5'd0; i_req0_op = 2'b00;
        i_req1_valid = 1'b1; i_req1_data = 32'h22; i_req1_shamt = 5'd1; i_req1_op = 2'b00;
        for (int i = 0; i < 6; i++) begin
            #1 check($sformatf("t3_ready%0d", i), rdy(), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check($sformatf("t3_src%0d", i), {31'b0, o_rsp_src}, (i % 2 == 0) ? 32'h0 : 32'h1);
            check($sformatf("t3_data%0d", i), o_rsp_data, (i % 2 == 0) ? 32'h11 : 32'h44);
        end

        // Backpressure with both still valid
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("t4_ready%0d", i), rdy(), 32'h0);
            tick();
            check($sformatf("t4_valid%0d", i), {31'b0, o_rsp_valid}, 32'h1);
            check($sformatf("t4_data%0d", i), o_rsp_data, 32'h44);
            check($sformatf("t4_src%0d", i), {31'b0, o_rsp_src}, 32'h1);
        end
        i_rsp_ready = 1'b1;
        #1 check("t4_release_ready", rdy(), 32'h1);
        tick();
        check("t4_next_valid", {31'b0, o_rsp_valid}, 32'h1);
        check("t4_next_src", {31'b0, o_rsp_src}, 32'h0);
        check("t4_next_data", o_rsp_data, 32'h11);
        tick();
        check("t4_after_src", {31'b0, o_rsp_src}, 32'h1);
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        tick();

        // Accept on requester 1, then requester 0 (pointer -> 1), then reset mid-cycle
        i_req1_valid = 1'b1; i_req1_data = 32'h0000_00F0; i_req1_shamt = 5'd4; i_req1_op = 2'b01;
        tick();
        i_req1_valid = 1'b0;
        check("t5_src1", {31'b0, o_rsp_src}, 32'h1);
        check("t5_data1", o_rsp_data, 32'h0000_000F);
        i_req0_valid = 1'b1; i_req0_data = 32'h3; i_req0_shamt = 5'd2; i_req0_op = 2'b00;
        tick();
        i_req0_valid = 1'b0;
        i_rsp_ready = 1'b0;
        check("t5_src0", {31'b0, o_rsp_src}, 32'h0);
        #3 i_rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'b0, o_rsp_valid}, 32'h0);
        check("t5_rst_data", o_rsp_data, 32'h0);
        #2 i_rst_n = 1'b1;
        i_rsp_ready = 1'b1;
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        #1 check("t5_prio_ready", rdy(), 32'h1);
        tick();
        check("t5_prio_src", {31'b0, o_rsp_src}, 32'h0);
        check("t5_prio_data", o_rsp_data, 32'hC);
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        tick();

        // Shamt sweep on requester 0
        i_req0_data = 32'hA5A5_A5A5;
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 32; s++) begin
                i_req0_valid = 1'b1; i_req0_op = sweep_ops[k]; i_req0_shamt = 5'(s);
                tick();
                check($sformatf("sweep_op%0d_s%0d", sweep_ops[k], s), o_rsp_data,
                      ref_shift(32'hA5A5_A5A5, 5'(s), sweep_ops[k]));
            end
        end
        i_req0_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
